fwd_operand_reg: RTL and testbench
==================================

# fwd_operand_reg

Parametrised operand-forwarding stage for the MIPS pipeline, the next generation of the fixed 3-way forwarding mux. It compares the consuming instruction's source register against the destination of up to STAGES younger-to-older pipeline stages, selects the youngest valid producer (or the register file), detects load-use hazards, and registers the selected operand into the ID/EX boundary with stall and flush control. It also keeps a saturating hazard-cycle counter for performance analysis.

## Interface
- N, 32, data width
- STAGES, 3, number of forwarding sources (stage 0 = youngest, e.g. EX/MEM)
- AW, 5, register address width
- CW, 16, hazard counter width
- SELW (local), $clog2(STAGES+1), source-select width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  consuming instruction present this cycle
- stall  in  1  hold output register
- flush  in  1  load bubble into output register
- rs_addr  in  AW  source register of consuming instruction
- rf_data  in  N  register file read data for rs_addr
- fwd_we  in  STAGES  stage k will write a register
- fwd_ready  in  STAGES  stage k result available now (0 for load still in EX)
- fwd_addr  in  STAGES*AW  stage k destination, bits [k*AW +: AW]
- fwd_data  in  STAGES*N  stage k result, bits [k*N +: N]
- hazard  out  1  combinational: youngest match not ready
- op_out  out  N  registered operand
- op_valid  out  1  registered: op_out holds a valid operand
- src_sel  out  SELW  registered source: 0 = register file / zero, k+1 = stage k
- hazard_cnt  out  CW  saturating count of hazard cycles

## Operation
- Match k = fwd_we[k] && fwd_addr[k] == rs_addr && rs_addr != 0.
- Winner = lowest k with match; priority strictly youngest-first, older matches ignored.
- No match: selected data = rf_data, sel 0. rs_addr == 0: selected data = 0, sel 0, regardless of rf_data or fwd inputs.
- hazard = in_valid && winner exists && !fwd_ready[winner]. An older ready match never masks a younger unready one.
- Register update priority: rst > flush > stall > load.
  - rst: op_out 0, op_valid 0, src_sel 0, hazard_cnt 0.
  - flush: op_valid 0, src_sel 0; op_out holds.
  - stall: all registers hold.
  - load, in_valid && !hazard: op_out = selected data, src_sel = winner+1 or 0, op_valid 1.
  - load, otherwise: op_valid 0 (bubble); op_out, src_sel hold.
- hazard_cnt increments by 1 on every cycle with hazard = 1 and rst = 0, independent of stall/flush; saturates at 2^CW-1, never wraps.
- STAGES = 1 must be supported; SELW is then 1.

## Timing
- hazard: zero-cycle, combinational from inputs.
- Operand latency: 1 cycle; inputs sampled at edge t appear on op_out/op_valid/src_sel after edge t.
- Hazard resolution: producer raises fwd_ready in cycle t -> hazard drops in cycle t -> operand captured at edge ending t (if not stalled/flushed).
- Simultaneous flush and stall: flush wins. Reset mid-operation clears all state on the next edge; inputs in that cycle are discarded.
- No combinational path from inputs to op_out, op_valid, src_sel, or hazard_cnt.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 and matching inputs -> op_out 0, op_valid 0, src_sel 0, hazard_cnt 0.
- No match: rs_addr=7, rf_data=0x1111_1111, all fwd_we=0 -> next cycle op_out 0x1111_1111, src_sel 0, op_valid 1.
- Priority: rs_addr=9; stage 0 and stage 2 both write r9 with data 0xAAAA_0000 / 0xCCCC_0000, all ready -> op_out 0xAAAA_0000, src_sel 1. Drop stage 0 we -> op_out 0xCCCC_0000, src_sel 3.
- $zero: rs_addr=0, stage 0 writes r0 with 0xDEAD_BEEF, rf_data=0x5 -> op_out 0, src_sel 0, hazard 0.
- Load-use: stage 0 matches r4 with fwd_ready[0]=0 for 2 cycles, then 1 with data 0x42 -> hazard 1 for 2 cycles, op_valid 0 during them, hazard_cnt=2, then op_out 0x42, src_sel 1, op_valid 1.
- Stall/flush/saturation: CW=2, hold hazard 5 cycles -> hazard_cnt stops at 3; stall=1 with new input -> outputs unchanged; stall=1 and flush=1 together -> op_valid 0, op_out unchanged.

Source files
------------

// File: rtl/fwd_operand_reg.sv
// ----------------------------------------------------------------------------
// fwd_operand_reg
//
// Operand-forwarding stage for the ID/EX boundary. It compares the consuming
// instruction's source register against the destinations of STAGES pipeline
// stages, with stage 0 the youngest. It picks the youngest valid producer, or
// the register file when no stage matches. If that youngest producer is not
// ready yet (a load-use case), it raises hazard. The selected operand is
// registered with flush and stall control. A saturating counter records every
// hazard cycle.
//
// Parameters
//   N       data width
//   STAGES  number of forwarding sources (stage 0 = youngest)
//   AW      register address width
//   CW      hazard counter width
//   SELW    source-select width (derived, not overridable)
//
// Ports
//   clk         clock; every state update happens on the rising edge
//   rst         synchronous active-high reset
//   in_valid    a consuming instruction is present this cycle
//   stall       hold every output register
//   flush       load a bubble into the output register
//   rs_addr     source register of the consuming instruction
//   rf_data     register file read data for rs_addr
//   fwd_we      stage k will write a register
//   fwd_ready   stage k result is available now
//   fwd_addr    stage k destination register, bits [k*AW +: AW]
//   fwd_data    stage k result, bits [k*N +: N]
//   hazard      combinational: the youngest matching stage is not ready
//   op_out      registered operand
//   op_valid    registered: op_out holds a valid operand
//   src_sel     registered source: 0 = register file / $zero, k+1 = stage k
//   hazard_cnt  saturating count of hazard cycles
// ----------------------------------------------------------------------------
module fwd_operand_reg #(
    parameter  int N      = 32,
    parameter  int STAGES = 3,
    parameter  int AW     = 5,
    parameter  int CW     = 16,
    localparam int SELW   = $clog2(STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [AW-1:0]        rs_addr,
    input  logic [N-1:0]         rf_data,
    input  logic [STAGES-1:0]    fwd_we,
    input  logic [STAGES-1:0]    fwd_ready,
    input  logic [STAGES*AW-1:0] fwd_addr,
    input  logic [STAGES*N-1:0]  fwd_data,
    output logic                 hazard,
    output logic [N-1:0]         op_out,
    output logic                 op_valid,
    output logic [SELW-1:0]      src_sel,
    output logic [CW-1:0]        hazard_cnt
);

    logic            win_found;
    logic            win_ready;
    logic [SELW-1:0] win_sel;
    logic [N-1:0]    win_data;
    logic [N-1:0]    sel_data;

    // Youngest-first priority select. Once a match is found, older stages are
    // ignored. This keeps a ready older producer from masking an unready
    // younger one. Register $zero never matches, so it never forwards.
    // NOTE: each variable assigned in this block gets a default value first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_ready = 1'b0;
        win_sel   = '0;
        win_data  = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (!win_found && fwd_we[k] && rs_addr != '0 &&
                fwd_addr[k*AW +: AW] == rs_addr) begin
                win_found = 1'b1;
                win_ready = fwd_ready[k];
                win_sel   = SELW'(k + 1);
                win_data  = fwd_data[k*N +: N];
            end
        end
    end

    // $zero always reads as 0, whatever the register file port returns.
    assign sel_data = (rs_addr == '0) ? '0 : (win_found ? win_data : rf_data);
    assign hazard   = in_valid && win_found && !win_ready;

    // Priority: reset, then flush, then stall, then load. The hazard counter
    // is outside the flush/stall chain because it counts every hazard cycle.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge, whatever the order of
    // the statements.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_out     <= '0;
            op_valid   <= 1'b0;
            src_sel    <= '0;
            hazard_cnt <= '0;
        end else begin
            if (hazard && hazard_cnt != '1)
                hazard_cnt <= hazard_cnt + 1'b1;

            if (flush) begin
                op_valid <= 1'b0;
                src_sel  <= '0;
            end else if (!stall) begin
                if (in_valid && !hazard) begin
                    op_out   <= sel_data;
                    src_sel  <= win_sel;
                    op_valid <= 1'b1;
                end else begin
                    // Bubble: op_out and src_sel keep their last values.
                    op_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fwd_operand_reg.sv
// ----------------------------------------------------------------------------
// tb_fwd_operand_reg
//
// Directed-vector bench for fwd_operand_reg (N=32, STAGES=3, AW=5, CW=2).
//
// On each falling edge, the stimulus process drives one vector. It pushes
// the hand-computed response for that vector into a queue: the expected
// combinational hazard, plus the register state expected after the next
// rising edge.
//
// A separate monitor pops each entry. It samples hazard before the rising
// edge and the registered outputs 1 time unit after it, then compares both
// against the entry.
// ----------------------------------------------------------------------------
module tb_fwd_operand_reg;

    localparam int N      = 32;
    localparam int STAGES = 3;
    localparam int AW     = 5;
    localparam int CW     = 2;
    localparam int SELW   = $clog2(STAGES + 1);

    typedef struct {
        logic        hz;
        logic [31:0] out;
        logic        v;
        logic [1:0]  sel;
        logic [1:0]  cnt;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 stall;
    logic                 flush;
    logic [AW-1:0]        rs_addr;
    logic [N-1:0]         rf_data;
    logic [STAGES-1:0]    fwd_we;
    logic [STAGES-1:0]    fwd_ready;
    logic [STAGES*AW-1:0] fwd_addr;
    logic [STAGES*N-1:0]  fwd_data;
    logic                 hazard;
    logic [N-1:0]         op_out;
    logic                 op_valid;
    logic [SELW-1:0]      src_sel;
    logic [CW-1:0]        hazard_cnt;

    exp_t exp_q[$];
    int   n_pushed;
    int   n_vec;
    int   n_miss;

    fwd_operand_reg #(.N(N), .STAGES(STAGES), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall),
        .flush(flush), .rs_addr(rs_addr), .rf_data(rf_data),
        .fwd_we(fwd_we), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .hazard(hazard), .op_out(op_out),
        .op_valid(op_valid), .src_sel(src_sel), .hazard_cnt(hazard_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int vec,
                         input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL vec%0d %s: got 0x%08h, expected 0x%08h",
                     vec, name, act, exp);
        end
    endtask

    // Drive one vector and queue its expected response.
    task automatic apply(input logic r, input logic iv, input logic st,
                         input logic fl, input logic [4:0] rs,
                         input logic [31:0] rf, input logic [2:0] we,
                         input logic [2:0] rdy, input logic [14:0] addr,
                         input logic [95:0] data, input logic eh,
                         input logic [31:0] eo, input logic ev,
                         input logic [1:0] es, input logic [1:0] ec);
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = iv; stall = st; flush = fl;
        rs_addr = rs; rf_data = rf; fwd_we = we; fwd_ready = rdy;
        fwd_addr = addr; fwd_data = data;
        e.hz = eh; e.out = eo; e.v = ev; e.sel = es; e.cnt = ec;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    // Monitor: check hazard before the edge, registered outputs after it.
    initial begin
        exp_t e;
        logic hz_s;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() != 0) begin
                e    = exp_q.pop_front();
                hz_s = hazard;
                @(posedge clk);
                #1;
                n_vec++;
                check("hazard",     n_vec, 32'(hz_s),       32'(e.hz));
                check("op_out",     n_vec, op_out,          e.out);
                check("op_valid",   n_vec, 32'(op_valid),   32'(e.v));
                check("src_sel",    n_vec, 32'(src_sel),    32'(e.sel));
                check("hazard_cnt", n_vec, 32'(hazard_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        n_pushed = 0; n_vec = 0; n_miss = 0;
        rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        rs_addr = '0; rf_data = '0; fwd_we = '0; fwd_ready = '0;
        fwd_addr = '0; fwd_data = '0;

        // Reset for two cycles while a ready stage-0 producer matches.
        apply(1,1,0,0, 5'd9, 32'h1234, 3'b001, 3'b111, {5'd0,5'd0,5'd9},
              {32'h0,32'h0,32'hAAAA0000}, 0, 32'h0, 0, 2'd0, 2'd0);
        apply(1,1,0,0, 5'd9, 32'h1234, 3'b001, 3'b111, {5'd0,5'd0,5'd9},
              {32'h0,32'h0,32'hAAAA0000}, 0, 32'h0, 0, 2'd0, 2'd0);
        // No match: the register file supplies the operand.
        apply(0,1,0,0, 5'd7, 32'h11111111, 3'b000, 3'b111, {5'd7,5'd7,5'd7},
              {32'h1,32'h2,32'h3}, 0, 32'h11111111, 1, 2'd0, 2'd0);
        // Stages 0 and 2 both write r9: stage 0 wins.
        apply(0,1,0,0, 5'd9, 32'h99, 3'b101, 3'b111, {5'd9,5'd3,5'd9},
              {32'hCCCC0000,32'hBBBB0000,32'hAAAA0000}, 0, 32'hAAAA0000, 1, 2'd1, 2'd0);
        // Drop the stage 0 write: stage 2 supplies the operand.
        apply(0,1,0,0, 5'd9, 32'h99, 3'b100, 3'b111, {5'd9,5'd3,5'd9},
              {32'hCCCC0000,32'hBBBB0000,32'hAAAA0000}, 0, 32'hCCCC0000, 1, 2'd3, 2'd0);
        // Stages 1 and 2 both match: stage 1 wins.
        apply(0,1,0,0, 5'd9, 32'h99, 3'b110, 3'b111, {5'd9,5'd9,5'd9},
              {32'hCCCC0000,32'hBBBB0000,32'hAAAA0000}, 0, 32'hBBBB0000, 1, 2'd2, 2'd0);
        // $zero reads as 0 even though stage 0 writes r0.
        apply(0,1,0,0, 5'd0, 32'h5, 3'b111, 3'b111, {5'd0,5'd0,5'd0},
              {32'h1,32'h2,32'hDEADBEEF}, 0, 32'h0, 1, 2'd0, 2'd0);
        // Load-use on r4: stage 0 is unready; a ready stage 2 must not mask it.
        apply(0,1,0,0, 5'd4, 32'h0, 3'b101, 3'b100, {5'd4,5'd0,5'd4},
              {32'h77,32'h0,32'h42}, 1, 32'h0, 0, 2'd0, 2'd1);
        apply(0,1,0,0, 5'd4, 32'h0, 3'b101, 3'b100, {5'd4,5'd0,5'd4},
              {32'h77,32'h0,32'h42}, 1, 32'h0, 0, 2'd0, 2'd2);
        // Stage 0 becomes ready: the operand is captured the same cycle.
        apply(0,1,0,0, 5'd4, 32'h0, 3'b101, 3'b101, {5'd4,5'd0,5'd4},
              {32'h77,32'h0,32'h42}, 0, 32'h42, 1, 2'd1, 2'd2);
        // Stall with a new input: every register holds.
        apply(0,1,1,0, 5'd7, 32'h12345678, 3'b000, 3'b111, {5'd0,5'd0,5'd0},
              {32'h0,32'h0,32'h0}, 0, 32'h42, 1, 2'd1, 2'd2);
        // Stall and flush together: flush wins; op_out holds.
        apply(0,1,1,1, 5'd7, 32'h12345678, 3'b000, 3'b111, {5'd0,5'd0,5'd0},
              {32'h0,32'h0,32'h0}, 0, 32'h42, 0, 2'd0, 2'd2);
        // Forward from stage 1.
        apply(0,1,0,0, 5'd7, 32'h13, 3'b010, 3'b111, {5'd0,5'd7,5'd0},
              {32'h0,32'h5555,32'h0}, 0, 32'h5555, 1, 2'd2, 2'd2);
        // No instruction: a bubble, no hazard; op_out and src_sel hold.
        apply(0,0,0,0, 5'd4, 32'h0, 3'b001, 3'b000, {5'd0,5'd0,5'd4},
              {32'h0,32'h0,32'h66}, 0, 32'h5555, 0, 2'd2, 2'd2);
        // Hazard under stall: the counter still counts.
        apply(0,1,1,0, 5'd4, 32'h0, 3'b001, 3'b000, {5'd0,5'd0,5'd4},
              {32'h0,32'h0,32'h66}, 1, 32'h5555, 0, 2'd2, 2'd3);
        // Hazard under flush: the counter saturates at 3.
        apply(0,1,0,1, 5'd4, 32'h0, 3'b001, 3'b000, {5'd0,5'd0,5'd4},
              {32'h0,32'h0,32'h66}, 1, 32'h5555, 0, 2'd0, 2'd3);
        apply(0,1,0,0, 5'd4, 32'h0, 3'b001, 3'b000, {5'd0,5'd0,5'd4},
              {32'h0,32'h0,32'h66}, 1, 32'h5555, 0, 2'd0, 2'd3);
        apply(0,1,0,0, 5'd4, 32'h0, 3'b001, 3'b000, {5'd0,5'd0,5'd4},
              {32'h0,32'h0,32'h66}, 1, 32'h5555, 0, 2'd0, 2'd3);
        // Reset mid-hazard: all state clears; hazard itself stays combinational.
        apply(1,1,0,0, 5'd4, 32'h0, 3'b001, 3'b000, {5'd0,5'd0,5'd4},
              {32'h0,32'h0,32'h66}, 1, 32'h0, 0, 2'd0, 2'd0);
        // After reset: the producer is ready and its operand is captured.
        apply(0,1,0,0, 5'd4, 32'h0, 3'b001, 3'b001, {5'd0,5'd0,5'd4},
              {32'h0,32'h0,32'hABCD}, 0, 32'hABCD, 1, 2'd1, 2'd0);

        // Wait for the monitor to finish, with a bounded cycle budget.
        for (int i = 0; i < 50 && n_vec < n_pushed; i++) @(posedge clk);
        #2;
        if (n_vec < n_pushed) begin
            n_miss++;
            $display("FAIL monitor_timeout: checked %0d, expected %0d",
                     n_vec, n_pushed);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
